// File: rtl/s32x_video_mixer_pkg.sv
// s32x_video_mixer_pkg: shared MD pixel word type, delay limit and colour expansion helpers
package s32x_video_mixer_pkg;
  localparam int MIX_DELAY_MAX = 7;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hbl;
    logic       vbl;
    logic       hs_n;
    logic       vs_n;
  } MD_PIX_t;
  localparam MD_PIX_t MD_BLANK = '{r: 4'h0, g: 4'h0, b: 4'h0, hbl: 1'b1, vbl: 1'b1, hs_n: 1'b1, vs_n: 1'b1};
  function automatic logic [7:0] EXP5_8(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction
  function automatic logic [7:0] EXP4_8(input logic [3:0] c);
    return {c, c};
  endfunction
endpackage

// File: rtl/s32x_video_mixer_if.sv
// s32x_video_mixer_if: dot enable, config, MD/32X pixel inputs and mixed video outputs
interface s32x_video_mixer_if;
  logic       DOT_CE;
  logic       EN32X;
  logic [2:0] MD_DELAY;
  logic [3:0] MD_R, MD_G, MD_B;
  logic       MD_HBL, MD_VBL, MD_HS_N, MD_VS_N;
  logic [4:0] X_R, X_G, X_B;
  logic       X_YSO_N;
  logic [7:0] R, G, B;
  logic       HS_N, VS_N, HBLANK, VBLANK, LOCKED;
  modport master (
    output DOT_CE, EN32X, MD_DELAY, MD_R, MD_G, MD_B, MD_HBL, MD_VBL, MD_HS_N, MD_VS_N,
           X_R, X_G, X_B, X_YSO_N,
    input  R, G, B, HS_N, VS_N, HBLANK, VBLANK, LOCKED
  );
  modport slave (
    input  DOT_CE, EN32X, MD_DELAY, MD_R, MD_G, MD_B, MD_HBL, MD_VBL, MD_HS_N, MD_VS_N,
           X_R, X_G, X_B, X_YSO_N,
    output R, G, B, HS_N, VS_N, HBLANK, VBLANK, LOCKED
  );
endinterface

// File: rtl/s32x_video_mixer_mixdly.sv
// s32x_video_mixer_mixdly: circular MD delay RAM, read-before-write, delay 0 bypasses to the input
module s32x_video_mixer_mixdly
  import s32x_video_mixer_pkg::*;
#(
  parameter int DEPTH = MIX_DELAY_MAX + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          i_ce,
  input  logic [AW-1:0] i_delay,
  input  MD_PIX_t       i_pix,
  output MD_PIX_t       o_pix
);
  MD_PIX_t       r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] w_rp;
  assign w_rp  = r_wp - i_delay;
  assign o_pix = (i_delay == '0) ? i_pix : r_mem[w_rp];
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_wp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= MD_BLANK;
    end else if (i_ce) begin
      r_mem[r_wp] <= i_pix;
      r_wp        <= r_wp + 1'b1;
    end
endmodule

// File: rtl/s32x_video_mixer.sv
// s32x_video_mixer: aligns MD and 32X dot streams, selects per pixel and tracks 32X frame lock
module s32x_video_mixer
  import s32x_video_mixer_pkg::*;
#(
  parameter int MAX_DELAY = MIX_DELAY_MAX
) (
  input logic CLK,
  input logic RST_N,
  s32x_video_mixer_if.slave vif
);
  localparam int AW = $clog2(MAX_DELAY + 1);
  MD_PIX_t     w_md_in, w_md_dly, r_s1_md;
  logic [4:0]  r_s1_xr, r_s1_xg, r_s1_xb;
  logic        r_s1_yso;
  logic [23:0] r_rgb, w_rgb;
  logic        r_hs_n, r_vs_n, r_hbl, r_vbl;
  logic [1:0]  r_fc, w_fc_nxt;
  logic        r_tog, w_tog_nxt, r_locked;
  logic        w_blank, w_sel, w_tog_any, w_fall;
  assign w_md_in = {vif.MD_R, vif.MD_G, vif.MD_B, vif.MD_HBL, vif.MD_VBL, vif.MD_HS_N, vif.MD_VS_N};
  s32x_video_mixer_mixdly #(.DEPTH(MAX_DELAY + 1)) u_mixdly (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_ce    (vif.DOT_CE),
    .i_delay (AW'(vif.MD_DELAY)),
    .i_pix   (w_md_in),
    .o_pix   (w_md_dly)
  );
  assign w_blank = r_s1_md.hbl | r_s1_md.vbl;
  assign w_sel   = vif.EN32X & ~r_s1_yso & ~w_blank;
  assign w_rgb   = w_blank ? 24'h0 :
                   w_sel   ? {EXP5_8(r_s1_xr), EXP5_8(r_s1_xg), EXP5_8(r_s1_xb)} :
                             {EXP4_8(r_s1_md.r), EXP4_8(r_s1_md.g), EXP4_8(r_s1_md.b)};
  // a YSO_N change on the falling-edge dot still belongs to the frame that is ending
  assign w_tog_any = r_tog | (vif.DOT_CE & (vif.X_YSO_N != r_s1_yso));
  assign w_fall    = vif.DOT_CE & r_s1_md.vs_n & ~w_md_dly.vs_n;
  assign w_fc_nxt  = !vif.EN32X ? 2'd0 :
                     !w_fall    ? r_fc :
                     !w_tog_any ? 2'd0 :
                     (r_fc == 2'd2) ? 2'd2 : r_fc + 2'd1;
  assign w_tog_nxt = vif.EN32X & ~w_fall & w_tog_any;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_s1_md  <= MD_BLANK;
      r_s1_xr  <= '0;
      r_s1_xg  <= '0;
      r_s1_xb  <= '0;
      r_s1_yso <= 1'b1;
      r_rgb    <= '0;
      r_hs_n   <= 1'b1;
      r_vs_n   <= 1'b1;
      r_hbl    <= 1'b1;
      r_vbl    <= 1'b1;
    end else if (vif.DOT_CE) begin
      r_s1_md  <= w_md_dly;
      r_s1_xr  <= vif.X_R;
      r_s1_xg  <= vif.X_G;
      r_s1_xb  <= vif.X_B;
      r_s1_yso <= vif.X_YSO_N;
      r_rgb    <= w_rgb;
      r_hs_n   <= r_s1_md.hs_n;
      r_vs_n   <= r_s1_md.vs_n;
      r_hbl    <= r_s1_md.hbl;
      r_vbl    <= r_s1_md.vbl;
    end
  // lock state runs every CLK so that EN32X=0 clears it without waiting for a dot
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_fc     <= '0;
      r_tog    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_fc     <= w_fc_nxt;
      r_tog    <= w_tog_nxt;
      r_locked <= (w_fc_nxt == 2'd2);
    end
  assign vif.R      = r_rgb[23:16];
  assign vif.G      = r_rgb[15:8];
  assign vif.B      = r_rgb[7:0];
  assign vif.HS_N   = r_hs_n;
  assign vif.VS_N   = r_vs_n;
  assign vif.HBLANK = r_hbl;
  assign vif.VBLANK = r_vbl;
  assign vif.LOCKED = r_locked;
endmodule

// File: tb/tb_s32x_video_mixer.sv
// tb_s32x_video_mixer: directed vectors with hand-computed expectations for the video mixer
module tb_s32x_video_mixer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  localparam logic [28:0] RST_VEC = {24'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  s32x_video_mixer_if vif();
  s32x_video_mixer #(.MAX_DELAY(7)) dut (.CLK(clk), .RST_N(rst_n), .vif(vif));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [28:0] out_vec();
    return {vif.R, vif.G, vif.B, vif.HS_N, vif.VS_N, vif.HBLANK, vif.VBLANK, vif.LOCKED};
  endfunction
  function automatic logic [23:0] rgb();
    return {vif.R, vif.G, vif.B};
  endfunction
  task automatic step();
    vif.DOT_CE = 1'b1;
    @(posedge clk);
    #1;
    vif.DOT_CE = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic md(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b, input logic hbl);
    vif.MD_R = r;
    vif.MD_G = g;
    vif.MD_B = b;
    vif.MD_HBL = hbl;
  endtask
  task automatic frame(input bit tog, input bit exp_lock, input string tag);
    for (int i = 0; i < 8; i++) begin
      vif.MD_VS_N = (i >= 2);
      vif.X_YSO_N = tog ? ~i[0] : 1'b1;
      step();
      if (i == 0) chk(tag, 32'(vif.LOCKED), 32'(exp_lock));
    end
  endtask
  initial begin
    vif.DOT_CE = 0; vif.EN32X = 0; vif.MD_DELAY = 0;
    md(4'h0, 4'h0, 4'h0, 1'b0);
    vif.MD_VBL = 0; vif.MD_HS_N = 1; vif.MD_VS_N = 1;
    vif.X_R = 0; vif.X_G = 0; vif.X_B = 0; vif.X_YSO_N = 1;
    repeat (3) step();
    chk("reset_state", 32'(out_vec()), 32'(RST_VEC));
    rst_n = 1'b1;
    step();
    chk("first_dot_still_blank", 32'(vif.HBLANK), 32'd1);
    step();
    chk("active_after_2", 32'(vif.HBLANK), 32'd0);
    chk("syncs_after_2", {30'd0, vif.HS_N, vif.VS_N}, 32'd3);
    vif.EN32X = 1; vif.X_R = 5'h1F; vif.X_G = 5'h10; vif.X_B = 5'h00; vif.X_YSO_N = 0;
    step();
    chk("x_latency_1", 32'(rgb()), 32'h000000);
    step();
    chk("x_select", 32'(rgb()), 32'hFF8400);
    vif.X_YSO_N = 1;
    md(4'hF, 4'h8, 4'h0, 1'b0);
    repeat (2) step();
    chk("md_select", 32'(rgb()), 32'hFF8800);
    md(4'h3, 4'h3, 4'h3, 1'b0);
    vif.X_YSO_N = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_no_ce", 32'(rgb()), 32'hFF8800);
    vif.X_R = 5'h1F; vif.X_G = 5'h1F; vif.X_B = 5'h1F;
    md(4'hF, 4'hF, 4'hF, 1'b1);
    repeat (2) step();
    chk("blank_forces_black", {6'd0, rgb(), vif.HBLANK, vif.VBLANK}, {6'd0, 24'h0, 1'b1, 1'b0});
    vif.EN32X = 0; vif.X_YSO_N = 1; vif.MD_DELAY = 3;
    md(4'h0, 4'h0, 4'h0, 1'b0);
    repeat (8) step();
    md(4'hF, 4'hF, 4'hF, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      md(4'h0, 4'h0, 4'h0, 1'b0);
      if (k == 4) chk("d3_k4", 32'(rgb()), 32'h000000);
      if (k == 5) chk("d3_k5", 32'(rgb()), 32'hFFFFFF);
      if (k == 6) chk("d3_k6", 32'(rgb()), 32'h000000);
    end
    vif.MD_DELAY = 7;
    repeat (8) step();
    md(4'hF, 4'hF, 4'hF, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) md(4'h1, 4'h2, 4'h3, 1'b0);
      else md(4'h0, 4'h0, 4'h0, 1'b0);
      if (k == 8) chk("d7_k8", 32'(rgb()), 32'h000000);
      if (k == 9) chk("d7_k9", 32'(rgb()), 32'hFFFFFF);
      if (k == 10) chk("d7_k10_wrap", 32'(rgb()), 32'h112233);
      if (k == 11) chk("d7_k11", 32'(rgb()), 32'h000000);
    end
    vif.MD_DELAY = 0; vif.EN32X = 1;
    for (int i = 0; i < 4; i++) begin
      vif.X_YSO_N = i[0];
      step();
    end
    frame(1'b1, 1'b0, "lock_fc1");
    frame(1'b1, 1'b1, "lock_fc2");
    frame(1'b0, 1'b1, "lock_hold_at_stuck_start");
    frame(1'b1, 1'b0, "lock_lost_after_stuck");
    frame(1'b1, 1'b0, "relock_fc1");
    frame(1'b1, 1'b1, "relock_fc2");
    vif.EN32X = 0;
    @(posedge clk);
    #1;
    chk("en32x_drop_unlocks", 32'(vif.LOCKED), 32'd0);
    vif.X_YSO_N = 0;
    md(4'hA, 4'h5, 4'h3, 1'b0);
    repeat (2) step();
    chk("en32x_off_passthru", 32'(rgb()), 32'hAA5533);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_midline", 32'(out_vec()), 32'(RST_VEC));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
